// File: rtl/ascon_job_scheduler.sv
// rtl/ascon_job_scheduler.sv - round-robin job scheduler sharing one ascon core
`timescale 1ns/1ps
module ascon_job_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_WORDS  = 4,
    parameter int AD_LATENCY = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_sys_enable,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ*128-1:0] i_key,
    input  logic [NUM_REQ*128-1:0] i_nonce,
    input  logic [NUM_REQ*64-1:0]  i_data,
    input  logic [NUM_REQ-1:0]     i_data_valid,
    output logic [NUM_REQ-1:0]     o_data_ready,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [63:0]            o_cipher,
    output logic [NUM_REQ-1:0]     o_cipher_valid,
    output logic [127:0]           o_tag,
    output logic [NUM_REQ-1:0]     o_tag_valid,
    output logic                   o_busy,
    output logic                   o_core_start,
    output logic                   o_core_data_valid,
    output logic [63:0]            o_core_data,
    output logic [127:0]           o_core_key,
    output logic [127:0]           o_core_nonce,
    input  logic [63:0]            i_core_cipher,
    input  logic                   i_core_valid_cipher,
    input  logic [127:0]           i_core_tag,
    input  logic                   i_core_done
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AD_W  = $clog2(AD_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FEED, S_SEND, S_WAIT_AD, S_WAIT_CIPHER, S_WAIT_DONE
    } state_t;

    state_t               r_state, w_next;
    logic [PTR_W-1:0]     r_ptr, r_owner;
    logic [NUM_REQ-1:0]   r_grant, r_cipher_valid, r_tag_valid;
    logic                 r_busy;
    logic [127:0]         r_key, r_nonce, r_tag;
    logic [63:0]          r_word, r_cipher;
    logic [1:0]           r_count;
    logic [AD_W-1:0]      r_ad_cnt;

    logic                 w_found;
    logic [PTR_W-1:0]     w_sel, w_cand;
    logic [127:0]         w_key, w_nonce;
    logic [63:0]          w_odata;
    logic                 w_ovalid, w_last, w_ad_done;

    // Search upward from the pointer, wrapping, for the first active request.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_key    = '0;
        w_nonce  = '0;
        w_odata  = '0;
        w_ovalid = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (PTR_W'(r) == w_sel) begin
                w_key   = i_key[128*r +: 128];
                w_nonce = i_nonce[128*r +: 128];
            end
            if (PTR_W'(r) == r_owner) begin
                w_odata  = i_data[64*r +: 64];
                w_ovalid = i_data_valid[r];
            end
        end
    end

    assign w_last    = (r_count == 2'(NUM_WORDS - 1));
    assign w_ad_done = (r_ad_cnt == AD_W'(AD_LATENCY - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else if (i_sys_enable) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (w_found) w_next = S_START;
            S_START:       w_next = S_FEED;
            S_FEED:        if (w_ovalid) w_next = S_SEND;
            S_SEND:        w_next = (r_count == 2'd0) ? S_WAIT_AD : S_WAIT_CIPHER;
            S_WAIT_AD:     if (w_ad_done) w_next = S_FEED;
            S_WAIT_CIPHER: if (i_core_valid_cipher) w_next = w_last ? S_WAIT_DONE : S_FEED;
            S_WAIT_DONE:   if (i_core_done) w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr          <= '0;
            r_owner        <= '0;
            r_grant        <= '0;
            r_busy         <= 1'b0;
            r_key          <= '0;
            r_nonce        <= '0;
            r_word         <= '0;
            r_count        <= '0;
            r_ad_cnt       <= '0;
            r_cipher       <= '0;
            r_cipher_valid <= '0;
            r_tag          <= '0;
            r_tag_valid    <= '0;
        end else if (i_sys_enable) begin
            r_cipher_valid <= '0;
            r_tag_valid    <= '0;
            case (r_state)
                S_IDLE: if (w_found) begin
                    r_owner <= w_sel;
                    r_grant <= NUM_REQ'(1) << w_sel;
                    r_busy  <= 1'b1;
                    r_key   <= w_key;
                    r_nonce <= w_nonce;
                end
                S_FEED: if (w_ovalid) r_word <= w_odata;
                S_WAIT_AD: begin
                    if (w_ad_done) begin
                        r_ad_cnt <= '0;
                        r_count  <= r_count + 2'd1;
                    end else begin
                        r_ad_cnt <= r_ad_cnt + AD_W'(1);
                    end
                end
                S_WAIT_CIPHER: if (i_core_valid_cipher) begin
                    r_cipher       <= i_core_cipher;
                    r_cipher_valid <= r_grant;
                    if (!w_last) r_count <= r_count + 2'd1;
                end
                S_WAIT_DONE: if (i_core_done) begin
                    r_tag       <= i_core_tag;
                    r_tag_valid <= r_grant;
                    r_ptr       <= (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
                    r_grant     <= '0;
                    r_busy      <= 1'b0;
                    r_count     <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_data_ready      = (r_state == S_FEED) ? r_grant : '0;
    assign o_grant           = r_grant;
    assign o_cipher          = r_cipher;
    assign o_cipher_valid    = r_cipher_valid;
    assign o_tag             = r_tag;
    assign o_tag_valid       = r_tag_valid;
    assign o_busy            = r_busy;
    assign o_core_start      = (r_state == S_START);
    assign o_core_data_valid = (r_state == S_SEND);
    assign o_core_data       = r_word;
    assign o_core_key        = r_key;
    assign o_core_nonce      = r_nonce;
endmodule

// File: tb/tb_ascon_job_scheduler.sv
// tb/tb_ascon_job_scheduler.sv - scoreboard bench for ascon_job_scheduler with a core model
`timescale 1ns/1ps
module tb_ascon_job_scheduler;
    localparam int NR  = 4;
    localparam int NW  = 4;
    localparam int ADL = 8;

    logic              clock = 1'b0;
    logic              reset_n, i_sys_enable;
    logic [NR-1:0]     i_req, i_data_valid, o_data_ready, o_grant, o_cipher_valid, o_tag_valid;
    logic [NR*128-1:0] i_key, i_nonce;
    logic [NR*64-1:0]  i_data;
    logic [63:0]       o_cipher, o_core_data, i_core_cipher;
    logic [127:0]      o_tag, o_core_key, o_core_nonce, i_core_tag;
    logic              o_busy, o_core_start, o_core_data_valid, i_core_valid_cipher, i_core_done;

    ascon_job_scheduler #(.NUM_REQ(NR), .NUM_WORDS(NW), .AD_LATENCY(ADL)) dut (
        .clock(clock), .reset_n(reset_n), .i_sys_enable(i_sys_enable),
        .i_req(i_req), .i_key(i_key), .i_nonce(i_nonce), .i_data(i_data),
        .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .o_grant(o_grant),
        .o_cipher(o_cipher), .o_cipher_valid(o_cipher_valid), .o_tag(o_tag),
        .o_tag_valid(o_tag_valid), .o_busy(o_busy), .o_core_start(o_core_start),
        .o_core_data_valid(o_core_data_valid), .o_core_data(o_core_data),
        .o_core_key(o_core_key), .o_core_nonce(o_core_nonce),
        .i_core_cipher(i_core_cipher), .i_core_valid_cipher(i_core_valid_cipher),
        .i_core_tag(i_core_tag), .i_core_done(i_core_done));

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]   kind;   // 0 grant, 1 cipher, 2 tag
        logic [3:0]   owner;
        logic [127:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0, n_start = 0, n_dv = 0, mptr = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_to(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait expired, required event never seen", name);
    endtask

    function automatic logic [NR-1:0] oh(input int g);
        logic [NR-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic pop_exp(input logic [1:0] kind, output exp_t e, output bit ok);
        e = '0;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            ok = 1'b0;
            $display("FAIL sb_unexpected: output kind %0d seen, required none pending", kind);
        end else begin
            e  = sb_q.pop_front();
            ok = 1'b1;
            chk("sb_kind", 128'(e.kind), 128'(kind));
        end
    endtask

    // Monitor: compares every grant start, cipher pulse and tag pulse against the scoreboard.
    initial begin : monitor
        logic [NR-1:0] prev_grant;
        exp_t e;
        bit ok;
        prev_grant = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_grant = '0;
            end else begin
                if (o_core_start) n_start++;
                if (o_core_data_valid) n_dv++;
                if (o_grant != '0) chk("grant_onehot", 128'($onehot(o_grant)), 128'(1));
                if (prev_grant == '0 && o_grant != '0) begin
                    pop_exp(2'd0, e, ok);
                    if (ok) chk("grant_owner", 128'(o_grant), 128'(oh(int'(e.owner))));
                end
                if (o_cipher_valid != '0) begin
                    pop_exp(2'd1, e, ok);
                    if (ok) begin
                        chk("cipher_valid", 128'(o_cipher_valid), 128'(oh(int'(e.owner))));
                        chk("cipher", 128'(o_cipher), e.val);
                    end
                end
                if (o_tag_valid != '0) begin
                    pop_exp(2'd2, e, ok);
                    if (ok) begin
                        chk("tag_valid", 128'(o_tag_valid), 128'(oh(int'(e.owner))));
                        chk("tag", o_tag, e.val);
                    end
                end
                prev_grant = o_grant;
            end
        end
    end

    // Core model: cipher = data ^ key[63:0] ^ nonce[127:64]; tag = key ^ nonce halves swapped.
    initial begin : core_bfm
        int bcnt;
        logic [63:0] c;
        bcnt = 0;
        i_core_valid_cipher = 1'b0;
        i_core_done = 1'b0;
        i_core_cipher = '0;
        i_core_tag = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                bcnt = 0;
            end else begin
                if (o_core_start) bcnt = 0;
                if (o_core_data_valid) begin
                    bcnt++;
                    c = o_core_data ^ o_core_key[63:0] ^ o_core_nonce[127:64];
                    if (bcnt > 1) begin
                        repeat ($urandom_range(1, 3)) @(negedge clock);
                        if (reset_n) begin
                            i_core_cipher = c;
                            i_core_valid_cipher = 1'b1;
                            @(negedge clock);
                            i_core_valid_cipher = 1'b0;
                            if (bcnt == NW) begin
                                repeat ($urandom_range(1, 3)) @(negedge clock);
                                i_core_tag  = o_core_key ^ {o_core_nonce[63:0], o_core_nonce[127:64]};
                                i_core_done = 1'b1;
                                @(negedge clock);
                                i_core_done = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic run_job(input logic [NR-1:0] mask, input bit fz, input bit ab);
        int g, other, to, t0;
        logic [127:0] mkey, mnonce;
        logic [63:0] w [NW];
        exp_t e;
        for (int r = 0; r < NR; r++) begin
            i_key[128*r +: 128]   = rnd128();
            i_nonce[128*r +: 128] = rnd128();
        end
        g = -1;
        for (int i = 0; i < NR; i++)
            if (g < 0 && mask[(mptr + i) % NR]) g = (mptr + i) % NR;
        if (g < 0) return;
        other  = (g + 1) % NR;
        mkey   = i_key[128*g +: 128];
        mnonce = i_nonce[128*g +: 128];
        e = '{kind: 2'd0, owner: 4'(g), val: '0};
        sb_q.push_back(e);
        for (int k = 0; k < NW; k++) begin
            w[k] = {$urandom(), $urandom()};
            if (!ab && k > 0) begin
                e = '{kind: 2'd1, owner: 4'(g), val: 128'(w[k] ^ mkey[63:0] ^ mnonce[127:64])};
                sb_q.push_back(e);
            end
        end
        if (!ab) begin
            e = '{kind: 2'd2, owner: 4'(g), val: mkey ^ {mnonce[63:0], mnonce[127:64]}};
            sb_q.push_back(e);
        end
        n_start = 0;
        n_dv = 0;
        t0 = cyc;
        i_req = mask;
        to = 0;
        while (o_grant == '0 && to < 50) begin @(negedge clock); to++; end
        if (o_grant == '0) begin fail_to("grant_wait"); i_req = '0; return; end
        // Owner drops its request and scrambles key/nonce; a neighbour pokes a stray word.
        i_req[g] = 1'b0;
        i_key[128*g +: 128]   = '1;
        i_nonce[128*g +: 128] = rnd128();
        i_data[64*other +: 64] = {$urandom(), $urandom()};
        i_data_valid[other] = 1'b1;
        for (int k = 0; k < NW; k++) begin
            i_data[64*g +: 64] = w[k];
            i_data_valid[g] = 1'b1;
            if (fz && k == 1) begin
                repeat (2) @(negedge clock);
                i_sys_enable = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    chk("frozen_ready", 128'(o_data_ready), 128'(0));
                    chk("frozen_grant", 128'(o_grant), 128'(oh(g)));
                end
                i_sys_enable = 1'b1;
            end
            to = 0;
            while (!o_data_ready[g] && to < 100) begin
                chk("nonowner_ready", 128'(o_data_ready[other]), 128'(0));
                @(negedge clock);
                to++;
            end
            if (!o_data_ready[g]) begin
                fail_to("data_ready_wait");
                i_data_valid = '0;
                return;
            end
            if (k == 1) chk("ad_wait_cycles", 128'(cyc - t0), 128'(ADL + 1 + (fz ? 5 : 0)));
            chk("core_key_held", o_core_key, mkey);
            chk("core_nonce_held", o_core_nonce, mnonce);
            @(posedge clock);
            #1 i_data_valid[g] = 1'b0;
            @(negedge clock);
            chk("core_data_valid", 128'(o_core_data_valid), 128'(1));
            chk("core_data", 128'(o_core_data), 128'(w[k]));
            if (k == 0) t0 = cyc;
            if (ab && k == 1) begin
                @(posedge clock);
                #2 reset_n = 1'b0;
                #1;
                chk("rst_grant", 128'(o_grant), 128'(0));
                chk("rst_busy", 128'(o_busy), 128'(0));
                chk("rst_ready", 128'(o_data_ready), 128'(0));
                chk("rst_core_dv", 128'(o_core_data_valid), 128'(0));
                chk("rst_core_key", o_core_key, 128'(0));
                chk("rst_core_data", 128'(o_core_data), 128'(0));
                sb_q.delete();
                mptr = 0;
                i_req = '0;
                i_data_valid = '0;
                @(negedge clock);
                @(negedge clock);
                reset_n = 1'b1;
                repeat (6) @(negedge clock);
                chk("rst_no_tag", 128'(o_tag_valid), 128'(0));
                return;
            end
        end
        to = 0;
        while (o_tag_valid == '0 && to < 100) begin @(negedge clock); to++; end
        if (o_tag_valid == '0) begin
            fail_to("tag_wait");
        end else begin
            chk("end_grant", 128'(o_grant), 128'(0));
            chk("end_busy", 128'(o_busy), 128'(0));
            chk("start_pulses", 128'(n_start), 128'(1));
            chk("data_pulses", 128'(n_dv), 128'(NW));
        end
        mptr = (g + 1) % NR;
        i_req = '0;
        i_data_valid = '0;
    endtask

    initial begin : stimulus
        i_sys_enable = 1'b1;
        i_req = '0;
        i_data_valid = '0;
        i_key = '0;
        i_nonce = '0;
        i_data = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_grant", 128'(o_grant), 128'(0));
        chk("reset_busy", 128'(o_busy), 128'(0));
        chk("reset_cipher_valid", 128'(o_cipher_valid), 128'(0));
        chk("reset_tag_valid", 128'(o_tag_valid), 128'(0));
        chk("reset_core_start", 128'(o_core_start), 128'(0));
        chk("reset_tag", o_tag, 128'(0));
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_job(4'b0001, 1'b0, 1'b0);
        run_job(4'b1111, 1'b1, 1'b0);
        run_job(4'b0100, 1'b0, 1'b1);
        repeat (5) run_job(4'b1111, 1'b0, 1'b0);
        repeat (6) run_job(NR'($urandom_range(1, (1 << NR) - 1)), 1'b0, 1'b0);
        repeat (5) @(negedge clock);
        chk("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required summary before it");
        $fatal(1);
    end
endmodule
